// File: rtl/violet_io_port.sv
// rtl/violet_io_port.sv - Slow-bus I/O peripheral: console sink, 64-bit cycle counter, scratch, ID, exit.
// One request at a time over a four-phase valid/ready handshake; read data captured at acceptance.
module violet_io_port #(
  parameter int          LATENCY = 1,
  parameter logic [31:0] ID_WORD = 32'h56494F4C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sysbus_o_io_valid,
  input  logic        sysbus_o_io_write,
  input  logic [31:0] sysbus_o_io_addr,
  input  logic [31:0] sysbus_o_io_data,
  output logic        sysbus_i_io_ready,
  output logic [31:0] sysbus_i_io_data,
  output logic        console_valid,
  output logic [7:0]  console_byte,
  output logic        halt
);

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [5:0] OFF_CONSOLE  = 6'h00;
  localparam logic [5:0] OFF_CYCLE_LO = 6'h01;
  localparam logic [5:0] OFF_CYCLE_HI = 6'h02;
  localparam logic [5:0] OFF_SCRATCH0 = 6'h03;
  localparam logic [5:0] OFF_SCRATCH1 = 6'h04;
  localparam logic [5:0] OFF_EXIT     = 6'h05;
  localparam logic [5:0] OFF_ID       = 6'h06;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic [63:0]   cycle;
  logic [31:0]   hi_snap;
  logic [31:0]   scratch0;
  logic [31:0]   scratch1;
  logic [31:0]   rd_mux;
  logic [5:0]    off;
  logic          accept;
  logic          unused_addr;

  assign off         = sysbus_o_io_addr[7:2];
  assign unused_addr = ^{sysbus_o_io_addr[31:8], sysbus_o_io_addr[1:0]};
  assign accept      = (state == IDLE) && sysbus_o_io_valid && !sysbus_i_io_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (LATENCY > 1) ? WAIT : ACK;
      WAIT:    if (wait_cnt == CW'(1)) state_nx = ACK;
      ACK:     if (sysbus_i_io_ready && !sysbus_o_io_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_CYCLE_LO: rd_mux = cycle[31:0];
      OFF_CYCLE_HI: rd_mux = hi_snap;
      OFF_SCRATCH0: rd_mux = scratch0;
      OFF_SCRATCH1: rd_mux = scratch1;
      OFF_EXIT:     rd_mux = {31'b0, halt};
      OFF_ID:       rd_mux = ID_WORD;
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      cycle             <= 64'h0;
      hi_snap           <= 32'h0;
      scratch0          <= 32'h0;
      scratch1          <= 32'h0;
      sysbus_i_io_ready <= 1'b0;
      sysbus_i_io_data  <= 32'h0;
      console_valid     <= 1'b0;
      console_byte      <= 8'h0;
      halt              <= 1'b0;
    end else begin
      state         <= state_nx;
      cycle         <= cycle + 64'd1;
      console_valid <= 1'b0;
      if (state == WAIT) wait_cnt <= wait_cnt - CW'(1);
      // ready rises one edge after entering ACK and drops on the first edge valid is low
      if (state == ACK) begin
        if (!sysbus_i_io_ready) sysbus_i_io_ready <= 1'b1;
        else if (!sysbus_o_io_valid) sysbus_i_io_ready <= 1'b0;
      end
      if (accept) begin
        sysbus_i_io_data <= rd_mux;
        wait_cnt         <= CW'(LATENCY - 1);
        if (!sysbus_o_io_write && off == OFF_CYCLE_LO) hi_snap <= cycle[63:32];
        if (sysbus_o_io_write) begin
          case (off)
            OFF_CONSOLE: begin
              console_byte  <= sysbus_o_io_data[7:0];
              console_valid <= 1'b1;
            end
            OFF_SCRATCH0: scratch0 <= sysbus_o_io_data;
            OFF_SCRATCH1: scratch1 <= sysbus_o_io_data;
            OFF_EXIT:     halt     <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_violet_io_port.sv
// tb/tb_violet_io_port.sv - Directed self-checking bench for violet_io_port (LATENCY 1 and 4).
module tb_violet_io_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v1 = 0, w1 = 0, r1, cv1, h1;
  logic [31:0] a1 = 0, d1 = 0, q1;
  logic [7:0]  cb1;
  logic        v4 = 0, w4 = 0, r4, cv4, h4;
  logic [31:0] a4 = 0, d4 = 0, q4;
  logic [7:0]  cb4;

  violet_io_port #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .sysbus_o_io_valid(v1), .sysbus_o_io_write(w1), .sysbus_o_io_addr(a1), .sysbus_o_io_data(d1),
    .sysbus_i_io_ready(r1), .sysbus_i_io_data(q1),
    .console_valid(cv1), .console_byte(cb1), .halt(h1)
  );

  violet_io_port #(.LATENCY(4)) u4 (
    .clk(clk), .rst(rst),
    .sysbus_o_io_valid(v4), .sysbus_o_io_write(w4), .sysbus_o_io_addr(a4), .sysbus_o_io_data(d4),
    .sysbus_i_io_ready(r4), .sysbus_i_io_data(q4),
    .console_valid(cv4), .console_byte(cb4), .halt(h4)
  );

  localparam logic [31:0] ID = 32'h56494F4C;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int          cv_cnt = 0;
  logic [7:0]  cv_byte = 8'h0;
  always @(negedge clk) if (cv1 === 1'b1) begin cv_cnt++; cv_byte = cb1; end

  // reference cycle count: increments on every edge out of reset
  longint unsigned tb_cyc;
  always @(posedge clk or posedge rst)
    if (rst) tb_cyc <= 0;
    else tb_cyc <= tb_cyc + 1;

  task automatic xfer(input bit s4, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] rd, output int lat,
                      output longint unsigned acc);
    int n;
    @(negedge clk);
    acc = tb_cyc;
    if (s4) begin v4 = 1; w4 = wr; a4 = a; d4 = d; end
    else    begin v1 = 1; w1 = wr; a1 = a; d1 = d; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(s4 ? r4 : r1) && n < 50);
    lat = n;
    rd  = s4 ? q4 : q1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", s4 ? r4 : r1, 1);
      check("hold_data", s4 ? q4 : q1, rd);
    end
    @(negedge clk);
    if (s4) v4 = 0; else v1 = 0;
    @(posedge clk); #1;
    check("ready_drop", s4 ? r4 : r1, 0);
  endtask

  logic [31:0]     rd;
  int              lat;
  longint unsigned acc;
  int              n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", r1, 0);
    check("rst_data", q1, 0);
    check("rst_console_valid", cv1, 0);
    check("rst_console_byte", cb1, 0);
    check("rst_halt", h1, 0);
    rst = 0;

    // 1: ID read, ready after T+1, held while valid
    xfer(0, 0, 32'hF000_0018, 0, 2, rd, lat, acc);
    check("id_lat", lat, 2);
    check("id_data", rd, ID);

    // 2: scratch write/read, aliasing, unmapped and read-only
    xfer(0, 1, 32'hF000_000C, 32'hDEAD_BEEF, 0, rd, lat, acc);
    xfer(0, 0, 32'hF000_000C, 0, 0, rd, lat, acc);
    check("scratch0_rd", rd, 32'hDEAD_BEEF);
    xfer(0, 0, 32'hF000_0010, 0, 0, rd, lat, acc);
    check("scratch1_zero", rd, 0);
    xfer(0, 0, 32'hF000_0040, 0, 0, rd, lat, acc);
    check("unmapped_rd", rd, 0);
    xfer(0, 0, 32'hA500_010F, 0, 0, rd, lat, acc);
    check("alias_rd", rd, 32'hDEAD_BEEF);
    xfer(0, 1, 32'hF000_0018, 32'h1234_5678, 0, rd, lat, acc);
    xfer(0, 0, 32'hF000_0018, 0, 0, rd, lat, acc);
    check("id_ro", rd, ID);

    // 3: console strobe
    cv_cnt = 0;
    xfer(0, 1, 32'hF000_0000, 32'h0000_0141, 0, rd, lat, acc);
    repeat (2) @(negedge clk);
    check("console_cnt", cv_cnt, 1);
    check("console_byte", cv_byte, 8'h41);
    xfer(0, 0, 32'hF000_0000, 0, 0, rd, lat, acc);
    check("console_rd", rd, 0);

    // cycle counter value at acceptance
    xfer(0, 0, 32'hF000_0004, 0, 0, rd, lat, acc);
    check("cycle_lo", rd, acc[31:0]);
    xfer(0, 0, 32'hF000_0008, 0, 0, rd, lat, acc);
    check("cycle_hi", rd, 0);

    // 4: snapshot coherence across a 32-bit carry
    @(negedge clk);
    force u1.cycle = 64'h0000_0000_FFFF_FFFF;
    xfer(0, 0, 32'hF000_0004, 0, 0, rd, lat, acc);
    check("wrap_lo", rd, 32'hFFFF_FFFF);
    force u1.cycle = 64'h0000_0001_0000_0003;
    xfer(0, 0, 32'hF000_0008, 0, 0, rd, lat, acc);
    check("wrap_hi_snap", rd, 0);
    xfer(0, 0, 32'hF000_0004, 0, 0, rd, lat, acc);
    check("wrap_lo2", rd, 3);
    xfer(0, 0, 32'hF000_0008, 0, 0, rd, lat, acc);
    check("wrap_hi2", rd, 1);
    release u1.cycle;

    // 5: LATENCY=4, held ready, back-to-back, no re-decode
    xfer(1, 1, 32'hF000_000C, 32'h1234_5678, 3, rd, lat, acc);
    check("l4_wr_lat", lat, 5);
    xfer(1, 0, 32'hF000_000C, 0, 3, rd, lat, acc);
    check("l4_rd_lat", lat, 5);
    check("l4_rd_data", rd, 32'h1234_5678);
    @(negedge clk);
    v4 = 1; w4 = 0; a4 = 32'hF000_0018;
    @(posedge clk); #1;
    w4 = 1; a4 = 32'hF000_000C; d4 = 32'h0;
    n = 1;
    while (!r4 && n < 50) begin @(posedge clk); #1; n++; end
    check("l4_redecode_lat", n, 5);
    check("l4_redecode_data", q4, ID);
    @(negedge clk); v4 = 0;
    @(posedge clk); #1;
    check("l4_redecode_drop", r4, 0);
    xfer(1, 0, 32'hF000_000C, 0, 0, rd, lat, acc);
    check("l4_no_write", rd, 32'h1234_5678);

    // 6: reset during ACK, then exit
    @(negedge clk);
    v1 = 1; w1 = 0; a1 = 32'hF000_000C;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!r1 && n < 50);
    check("pre_rst_ready", r1, 1);
    #2 rst = 1;
    #1;
    check("rst_ack_ready", r1, 0);
    check("rst_ack_data", q1, 0);
    v1 = 0;
    @(negedge clk); rst = 0;
    xfer(0, 0, 32'hF000_000C, 0, 0, rd, lat, acc);
    check("rst_scratch0", rd, 0);
    xfer(0, 0, 32'hF000_0010, 0, 0, rd, lat, acc);
    check("rst_scratch1", rd, 0);
    xfer(0, 0, 32'hF000_0014, 0, 0, rd, lat, acc);
    check("exit_rd0", rd, 0);
    xfer(0, 1, 32'hF000_0014, 32'd7, 0, rd, lat, acc);
    check("halt_set", h1, 1);
    xfer(0, 0, 32'hF000_0014, 0, 0, rd, lat, acc);
    check("exit_rd1", rd, 1);
    check("halt_sticky", h1, 1);
    check("halt_local", h4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
